// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: opcode encoding, flag bundle and FSM states.
package alu_pkg;

    localparam int ALU_FUNC_W = 4;

    typedef enum logic [ALU_FUNC_W-1:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_AND = 4'd2,
        OP_ADC = 4'd3,
        OP_OR  = 4'd4,
        OP_XOR = 4'd5,
        OP_NOT = 4'd6,
        OP_SBB = 4'd7,
        OP_SHL = 4'd8,
        OP_SHR = 4'd9,
        OP_ASR = 4'd10,
        OP_MUL = 4'd11
    } alu_op_e;

    typedef struct packed {
        logic zero;
        logic positive;
        logic carry;
        logic overflow;
    } alu_flags_t;

    typedef enum logic {
        IDLE,
        MUL_BUSY
    } alu_state_e;

    localparam alu_flags_t FLAGS_RESET = '{zero: 1'b1, positive: 1'b1, carry: 1'b0, overflow: 1'b0};

    function automatic logic is_reserved(input logic [ALU_FUNC_W-1:0] func);
        return func > 4'd11;
    endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Unsigned shift-add multiplier: one partial product per clock, DATA_W iterations.
module alu_mul_iter #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] product_lo,
    output logic [DATA_W-1:0] product_hi
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

    logic                  busy_q, busy_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [2*DATA_W-1:0]   acc_q, acc_d, acc_next;
    logic [2*DATA_W-1:0]   mcand_q, mcand_d;
    logic [DATA_W-1:0]     mplier_q, mplier_d;

    always_comb begin
        acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);
        busy_d   = busy_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        if (start) begin
            busy_d   = 1'b1;
            cnt_d    = '0;
            acc_d    = '0;
            mcand_d  = {{DATA_W{1'b0}}, a};
            mplier_d = b;
        end else if (busy_q) begin
            acc_d    = acc_next;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else begin
            busy_q   <= busy_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
        end
    end

    // The final partial product is exposed combinationally so the caller can register it on the last iteration edge.
    assign busy       = busy_q;
    assign done       = busy_q && (cnt_q == LAST);
    assign product_lo = acc_next[DATA_W-1:0];
    assign product_hi = acc_next[2*DATA_W-1:DATA_W];

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle arithmetic/logic/shift ops plus an iterative multiply,
// with registered result, flags and a one-cycle response pulse.
module seq_alu
    import alu_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [DATA_W-1:0]     operand_a,
    input  logic [DATA_W-1:0]     operand_b,
    input  logic [ALU_FUNC_W-1:0] alu_func,
    input  logic                  output_enable,
    output logic [DATA_W-1:0]     alu_result,
    output logic                  rsp_valid,
    output logic                  rsp_err,
    output logic                  zero_flag,
    output logic                  positive_flag,
    output logic                  carry_flag,
    output logic                  signed_overflow
);

    localparam int SH_W = $clog2(DATA_W);

    if (DATA_W < 4 || (DATA_W & (DATA_W - 1)) != 0) begin : g_width_check
        $error("seq_alu: DATA_W must be a power of two and at least 4");
    end

    alu_state_e        state_q, state_d;
    logic [DATA_W-1:0] result_q, result_d;
    alu_flags_t        flags_q, flags_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_err_q, rsp_err_d;

    alu_op_e           op;
    logic              accept, mul_start, mul_busy, mul_done;
    logic [DATA_W-1:0] mul_lo, mul_hi;
    logic [SH_W-1:0]   amt;
    logic [DATA_W-1:0] b_eff, calc_res;
    logic              cin, calc_carry, calc_ovf;
    logic [DATA_W:0]   sum, shl_w, shr_w, asr_w;

    function automatic alu_flags_t make_flags(input logic [DATA_W-1:0] r, input logic c, input logic v);
        alu_flags_t f;
        f.zero     = (r == '0);
        f.positive = ~r[DATA_W-1];
        f.carry    = c;
        f.overflow = v;
        return f;
    endfunction

    assign op        = alu_op_e'(alu_func);
    assign req_ready = (state_q == IDLE) && !mul_busy;
    assign accept    = req_valid && req_ready;
    assign mul_start = accept && (alu_func == OP_MUL);

    alu_mul_iter #(
        .DATA_W(DATA_W)
    ) u_mul (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (mul_start),
        .a         (operand_a),
        .b         (operand_b),
        .busy      (mul_busy),
        .done      (mul_done),
        .product_lo(mul_lo),
        .product_hi(mul_hi)
    );

    // Shifts run one bit wider so the last bit shifted out lands in a fixed position.
    always_comb begin
        amt   = operand_b[SH_W-1:0];
        b_eff = (op == OP_SUB || op == OP_SBB) ? ~operand_b : operand_b;
        case (op)
            OP_SUB:         cin = 1'b1;
            OP_ADC, OP_SBB: cin = flags_q.carry;
            default:        cin = 1'b0;
        endcase
        sum   = {1'b0, operand_a} + {1'b0, b_eff} + {{DATA_W{1'b0}}, cin};
        shl_w = {1'b0, operand_a} << amt;
        shr_w = {operand_a, 1'b0} >> amt;
        asr_w = $signed({operand_a, 1'b0}) >>> amt;

        calc_res   = sum[DATA_W-1:0];
        calc_carry = sum[DATA_W];
        calc_ovf   = (operand_a[DATA_W-1] == b_eff[DATA_W-1]) && (sum[DATA_W-1] != operand_a[DATA_W-1]);
        case (op)
            OP_AND: begin calc_res = operand_a & operand_b; calc_carry = 1'b0; calc_ovf = 1'b0; end
            OP_OR:  begin calc_res = operand_a | operand_b; calc_carry = 1'b0; calc_ovf = 1'b0; end
            OP_XOR: begin calc_res = operand_a ^ operand_b; calc_carry = 1'b0; calc_ovf = 1'b0; end
            OP_NOT: begin calc_res = ~operand_a;            calc_carry = 1'b0; calc_ovf = 1'b0; end
            OP_SHL: begin calc_res = shl_w[DATA_W-1:0]; calc_carry = shl_w[DATA_W]; calc_ovf = 1'b0; end
            OP_SHR: begin calc_res = shr_w[DATA_W:1];   calc_carry = shr_w[0];      calc_ovf = 1'b0; end
            OP_ASR: begin calc_res = asr_w[DATA_W:1];   calc_carry = asr_w[0];      calc_ovf = 1'b0; end
            default: ;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        result_d    = result_q;
        flags_d     = flags_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (alu_func == OP_MUL) begin
                        state_d = MUL_BUSY;
                    end else if (is_reserved(alu_func)) begin
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else begin
                        result_d    = calc_res;
                        flags_d     = make_flags(calc_res, calc_carry, calc_ovf);
                        rsp_valid_d = 1'b1;
                    end
                end
            end
            MUL_BUSY: begin
                if (mul_done) begin
                    state_d     = IDLE;
                    result_d    = mul_lo;
                    flags_d     = make_flags(mul_lo, |mul_hi, 1'b0);
                    rsp_valid_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            result_q    <= '0;
            flags_q     <= FLAGS_RESET;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            result_q    <= result_d;
            flags_q     <= flags_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign alu_result      = output_enable ? result_q : 'z;
    assign rsp_valid       = rsp_valid_q;
    assign rsp_err         = rsp_err_q;
    assign zero_flag       = flags_q.zero;
    assign positive_flag   = flags_q.positive;
    assign carry_flag      = flags_q.carry;
    assign signed_overflow = flags_q.overflow;

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu (DATA_W=8): directed scenarios plus random ops
// compared against an arithmetic reference model.
module tb_seq_alu;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       req_valid = 1'b0;
    logic       output_enable = 1'b1;
    logic [7:0] operand_a = 8'h00;
    logic [7:0] operand_b = 8'h00;
    logic [3:0] alu_func = 4'h0;
    wire  [7:0] alu_result;
    logic       req_ready, rsp_valid, rsp_err;
    logic       zero_flag, positive_flag, carry_flag, signed_overflow;
    wire  [3:0] flags_obs = {zero_flag, positive_flag, carry_flag, signed_overflow};

    int tests = 0;
    int fails = 0;

    logic [7:0] m_res;
    logic       m_z, m_p, m_c, m_v;

    seq_alu #(.DATA_W(8)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .operand_a      (operand_a),
        .operand_b      (operand_b),
        .alu_func       (alu_func),
        .output_enable  (output_enable),
        .alu_result     (alu_result),
        .rsp_valid      (rsp_valid),
        .rsp_err        (rsp_err),
        .zero_flag      (zero_flag),
        .positive_flag  (positive_flag),
        .carry_flag     (carry_flag),
        .signed_overflow(signed_overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic model_reset();
        m_res = 8'h00; m_z = 1'b1; m_p = 1'b1; m_c = 1'b0; m_v = 1'b0;
    endtask

    // Reference model: plain integer arithmetic on the opcode's meaning.
    task automatic model_apply(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                               output logic err, output int lat);
        int ia, ib, sa, sb, amt, res, sres, c, v, p;
        ia = int'(a); ib = int'(b);
        sa = (ia >= 128) ? ia - 256 : ia;
        sb = (ib >= 128) ? ib - 256 : ib;
        amt = ib % 8;
        res = 0; sres = 0; c = 0; v = 0; err = 1'b0; lat = 1;
        case (op)
            4'd0:  begin res = ia + ib;                     sres = sa + sb; end
            4'd1:  begin res = ia + (255 - ib) + 1;         sres = sa - sb; end
            4'd3:  begin res = ia + ib + int'(m_c);         sres = sa + sb + int'(m_c); end
            4'd7:  begin res = ia + (255 - ib) + int'(m_c); sres = sa - sb - 1 + int'(m_c); end
            4'd2:  res = ia & ib;
            4'd4:  res = ia | ib;
            4'd5:  res = ia ^ ib;
            4'd6:  res = 255 - ia;
            4'd8:  begin res = (ia << amt) % 256; c = (amt == 0) ? 0 : (ia >> (8 - amt)) % 2; end
            4'd9:  begin res = ia >> amt;         c = (amt == 0) ? 0 : (ia >> (amt - 1)) % 2; end
            4'd10: begin res = (sa >>> amt) & 255; c = (amt == 0) ? 0 : (ia >> (amt - 1)) % 2; end
            4'd11: begin p = ia * ib; res = p % 256; c = (p >= 256) ? 1 : 0; lat = 9; end
            default: err = 1'b1;
        endcase
        if (op == 4'd0 || op == 4'd1 || op == 4'd3 || op == 4'd7) begin
            c = (res >= 256) ? 1 : 0;
            v = (sres < -128 || sres > 127) ? 1 : 0;
            res = res % 256;
        end
        if (!err) begin
            m_res = res[7:0];
            m_z   = (res == 0);
            m_p   = (res < 128);
            m_c   = c[0];
            m_v   = v[0];
        end
    endtask

    // Issues one request and waits (bounded) for its response; lat counts cycles after accept.
    task automatic do_request(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                              output int lat, output logic err_seen, output logic ready_seen);
        @(negedge clk);
        req_valid = 1'b1; alu_func = op; operand_a = a; operand_b = b;
        ready_seen = req_ready;
        @(posedge clk);
        lat = 0; err_seen = 1'b0;
        while (1) begin
            @(negedge clk);
            req_valid = 1'b0;
            lat++;
            if (rsp_valid) begin
                err_seen = rsp_err;
                break;
            end
            if (lat >= 20) break;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        tests++; if (alu_result !== 8'h00) begin fails++; $display("[TB] FAIL reset_result: got %h expected 00", alu_result); end
        tests++; if (flags_obs !== 4'b1100) begin fails++; $display("[TB] FAIL reset_flags: got %b expected 1100", flags_obs); end
        tests++; if ({rsp_valid, rsp_err} !== 2'b00) begin fails++; $display("[TB] FAIL reset_rsp: got %b expected 00", {rsp_valid, rsp_err}); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        tests++; if (req_ready !== 1'b1) begin fails++; $display("[TB] FAIL reset_ready: got %b expected 1", req_ready); end
        model_reset();
    endtask

    task automatic test_add_overflow();
        int lat; logic err, rdy, e; int l;
        model_apply(4'd0, 8'h7F, 8'h01, e, l);
        do_request(4'd0, 8'h7F, 8'h01, lat, err, rdy);
        tests++; if (lat !== 1) begin fails++; $display("[TB] FAIL add_latency: got %0d expected 1", lat); end
        tests++; if (alu_result !== 8'h80) begin fails++; $display("[TB] FAIL add_result: got %h expected 80", alu_result); end
        tests++; if (flags_obs !== 4'b0001) begin fails++; $display("[TB] FAIL add_flags: got %b expected 0001", flags_obs); end
        tests++; if (err !== 1'b0) begin fails++; $display("[TB] FAIL add_err: got %b expected 0", err); end
    endtask

    task automatic test_back_to_back();
        logic e; int l;
        model_apply(4'd1, 8'h05, 8'h05, e, l);
        model_apply(4'd7, 8'h10, 8'h01, e, l);
        @(negedge clk);
        req_valid = 1'b1; alu_func = 4'd1; operand_a = 8'h05; operand_b = 8'h05;
        @(posedge clk);
        @(negedge clk);
        tests++; if ({rsp_valid, req_ready} !== 2'b11) begin fails++; $display("[TB] FAIL b2b_first_valid_ready: got %b expected 11", {rsp_valid, req_ready}); end
        tests++; if (alu_result !== 8'h00) begin fails++; $display("[TB] FAIL b2b_sub_result: got %h expected 00", alu_result); end
        tests++; if (flags_obs !== 4'b1110) begin fails++; $display("[TB] FAIL b2b_sub_flags: got %b expected 1110", flags_obs); end
        alu_func = 4'd7; operand_a = 8'h10; operand_b = 8'h01;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        tests++; if (rsp_valid !== 1'b1) begin fails++; $display("[TB] FAIL b2b_second_valid: got %b expected 1", rsp_valid); end
        tests++; if (alu_result !== 8'h0F) begin fails++; $display("[TB] FAIL b2b_sbb_result: got %h expected 0f", alu_result); end
        tests++; if (flags_obs !== 4'b0110) begin fails++; $display("[TB] FAIL b2b_sbb_flags: got %b expected 0110", flags_obs); end
        @(negedge clk);
        tests++; if (rsp_valid !== 1'b0) begin fails++; $display("[TB] FAIL b2b_pulse_end: got %b expected 0", rsp_valid); end
    endtask

    task automatic test_shifts();
        int lat; logic err, rdy, e; int l;
        model_apply(4'd9, 8'h81, 8'h01, e, l);
        do_request(4'd9, 8'h81, 8'h01, lat, err, rdy);
        tests++; if ({alu_result, flags_obs} !== {8'h40, 4'b0110}) begin fails++; $display("[TB] FAIL shr: got %h/%b expected 40/0110", alu_result, flags_obs); end
        model_apply(4'd10, 8'h80, 8'h03, e, l);
        do_request(4'd10, 8'h80, 8'h03, lat, err, rdy);
        tests++; if ({alu_result, flags_obs} !== {8'hF0, 4'b0000}) begin fails++; $display("[TB] FAIL asr: got %h/%b expected f0/0000", alu_result, flags_obs); end
        model_apply(4'd8, 8'hA5, 8'h08, e, l);
        do_request(4'd8, 8'hA5, 8'h08, lat, err, rdy);
        tests++; if ({alu_result, flags_obs} !== {8'hA5, 4'b0000}) begin fails++; $display("[TB] FAIL shl_zero: got %h/%b expected a5/0000", alu_result, flags_obs); end
    endtask

    task automatic test_mul_busy();
        int ready_low, rsp_at, rsp_count; logic e; int l;
        logic [7:0] res_at_rsp; logic [3:0] flags_at_rsp;
        ready_low = 0; rsp_at = 0; rsp_count = 0; res_at_rsp = 8'h00; flags_at_rsp = 4'h0;
        model_apply(4'd11, 8'h10, 8'h11, e, l);
        @(negedge clk);
        req_valid = 1'b1; alu_func = 4'd11; operand_a = 8'h10; operand_b = 8'h11;
        @(posedge clk);
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (!req_ready) ready_low++;
            if (rsp_valid) begin
                rsp_count++; rsp_at = i; res_at_rsp = alu_result; flags_at_rsp = flags_obs;
            end
            if (i < 9) begin
                req_valid = 1'b1; alu_func = 4'd0; operand_a = 8'h01; operand_b = 8'h01;
            end else begin
                req_valid = 1'b0;
            end
        end
        tests++; if (ready_low !== 8) begin fails++; $display("[TB] FAIL mul_ready_low: got %0d expected 8", ready_low); end
        tests++; if (rsp_at !== 9) begin fails++; $display("[TB] FAIL mul_latency: got %0d expected 9", rsp_at); end
        tests++; if (rsp_count !== 1) begin fails++; $display("[TB] FAIL mul_rsp_count: got %0d expected 1", rsp_count); end
        tests++; if ({res_at_rsp, flags_at_rsp} !== {8'h10, 4'b0110}) begin fails++; $display("[TB] FAIL mul_result: got %h/%b expected 10/0110", res_at_rsp, flags_at_rsp); end
        tests++; if (alu_result !== 8'h10) begin fails++; $display("[TB] FAIL mul_busy_req_ignored: got %h expected 10", alu_result); end
    endtask

    task automatic test_reset_during_mul();
        int rsp_count;
        rsp_count = 0;
        @(negedge clk);
        req_valid = 1'b1; alu_func = 4'd11; operand_a = 8'($urandom_range(1, 255)); operand_b = 8'($urandom_range(1, 255));
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        tests++; if ({alu_result, flags_obs} !== {8'h00, 4'b1100}) begin fails++; $display("[TB] FAIL mulrst_state: got %h/%b expected 00/1100", alu_result, flags_obs); end
        tests++; if (rsp_valid !== 1'b0) begin fails++; $display("[TB] FAIL mulrst_rsp: got %b expected 0", rsp_valid); end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        tests++; if (req_ready !== 1'b1) begin fails++; $display("[TB] FAIL mulrst_ready: got %b expected 1", req_ready); end
        for (int i = 0; i < 12; i++) begin
            if (rsp_valid) rsp_count++;
            @(negedge clk);
        end
        tests++; if (rsp_count !== 0) begin fails++; $display("[TB] FAIL mulrst_no_rsp: got %0d expected 0", rsp_count); end
    endtask

    task automatic test_reserved();
        int lat; logic err, rdy, e; int l;
        model_apply(4'd0, 8'h7F, 8'h01, e, l);
        do_request(4'd0, 8'h7F, 8'h01, lat, err, rdy);
        model_apply(4'd13, 8'h33, 8'h44, e, l);
        do_request(4'd13, 8'h33, 8'h44, lat, err, rdy);
        tests++; if ({lat == 1, err} !== 2'b11) begin fails++; $display("[TB] FAIL reserved_rsp: got lat %0d err %b expected lat 1 err 1", lat, err); end
        tests++; if ({alu_result, flags_obs} !== {8'h80, 4'b0001}) begin fails++; $display("[TB] FAIL reserved_hold: got %h/%b expected 80/0001", alu_result, flags_obs); end
    endtask

    task automatic test_output_enable();
        output_enable = 1'b0;
        #1;
        tests++; if (alu_result === 8'h80) begin fails++; $display("[TB] FAIL oe_off: got %h expected not driven", alu_result); end
        output_enable = 1'b1;
        #1;
        tests++; if (alu_result !== 8'h80) begin fails++; $display("[TB] FAIL oe_on: got %h expected 80", alu_result); end
    endtask

    task automatic test_random();
        int lat, exp_lat; logic err, exp_err, rdy;
        logic [3:0] op; logic [7:0] a, b;
        for (int n = 0; n < 200; n++) begin
            op = 4'($urandom_range(0, 15));
            a  = 8'($urandom);
            b  = 8'($urandom);
            if (n % 5 == 0) b = 8'($urandom_range(0, 2));
            model_apply(op, a, b, exp_err, exp_lat);
            do_request(op, a, b, lat, err, rdy);
            tests++; if (rdy !== 1'b1) begin fails++; $display("[TB] FAIL rand_ready op %0d: got %b expected 1", op, rdy); end
            tests++; if (lat !== exp_lat || err !== exp_err) begin fails++; $display("[TB] FAIL rand_rsp op %0d: got lat %0d err %b expected lat %0d err %b", op, lat, err, exp_lat, exp_err); end
            tests++; if (alu_result !== m_res) begin fails++; $display("[TB] FAIL rand_result op %0d a %h b %h: got %h expected %h", op, a, b, alu_result, m_res); end
            tests++; if (flags_obs !== {m_z, m_p, m_c, m_v}) begin fails++; $display("[TB] FAIL rand_flags op %0d a %h b %h: got %b expected %b", op, a, b, flags_obs, {m_z, m_p, m_c, m_v}); end
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_add_overflow();
        test_back_to_back();
        test_shifts();
        test_mul_busy();
        test_reset_during_mul();
        test_reserved();
        test_output_enable();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
